// File: rtl/frame_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_stack_ctrl
// Description : Call/return frame sequencer. Pushes the live 15-register
//               frame onto an internal LIFO on call and replays it on return.
// Revision    : 1.0  initial release
// ============================================================================
module frame_stack_ctrl #(
  parameter int FRAME_W = 240,
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               call_req,
  input  logic               ret_req,
  input  logic [FRAME_W-1:0] fc_from_rf,
  output logic [FRAME_W-1:0] fc_to_rf,
  output logic               restore,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               full,
  output logic               empty,
  output logic [PTR_W:0]     depth
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RESTORE = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  localparam logic [PTR_W:0]   C_DEPTH_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   C_DEPTH_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] C_IDX_ONE    = PTR_W'(1);

  state_t               state_q, state_d;
  logic [PTR_W:0]       depth_q, depth_d;
  logic [FRAME_W-1:0]   fc_to_rf_q, fc_to_rf_d;
  logic                 err_q, err_d;
  logic [PTR_W-1:0]     pop_idx;

  // Stack storage is deliberately left out of reset so it maps onto plain RAM.
  logic [FRAME_W-1:0]   stack_mem [DEPTH];

  // Top-of-stack slot; modulo-DEPTH arithmetic also covers depth == DEPTH.
  assign pop_idx = depth_q[PTR_W-1:0] - C_IDX_ONE;

  assign full  = (depth_q == C_DEPTH_FULL);
  assign empty = (depth_q == '0);

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    fc_to_rf_d = fc_to_rf_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ret_req && !empty) begin
          state_d = ST_LOAD;
        end else if (ret_req) begin
          err_d = 1'b1;
        end else if (call_req && !full) begin
          state_d = ST_SAVE;
        end else if (call_req) begin
          err_d = 1'b1;
        end
      end
      ST_SAVE: begin
        depth_d = depth_q + C_DEPTH_ONE;
        state_d = ST_ACK;
      end
      ST_LOAD: begin
        depth_d    = depth_q - C_DEPTH_ONE;
        fc_to_rf_d = stack_mem[pop_idx];
        state_d    = ST_RESTORE;
      end
      ST_RESTORE: state_d = ST_ACK;
      ST_ACK:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      depth_q    <= '0;
      fc_to_rf_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      fc_to_rf_q <= fc_to_rf_d;
      err_q      <= err_d;
    end
  end

  // The frame is captured at the SAVE exit edge, not when the request is seen.
  always_ff @(posedge clk) begin
    if (state_q == ST_SAVE) begin
      stack_mem[depth_q[PTR_W-1:0]] <= fc_from_rf;
    end
  end

  assign fc_to_rf = fc_to_rf_q;
  assign err      = err_q;
  assign depth    = depth_q;
  assign busy     = (state_q != ST_IDLE);
  assign restore  = (state_q == ST_RESTORE);
  assign done     = (state_q == ST_ACK);

endmodule
`default_nettype wire
